// File: rtl/trap_controller_pkg.sv
// rtl/trap_controller_pkg.sv - shared types and constants for the machine-mode trap controller
package StaticPack;

  // Sequencer states: W_* write one trap CSR each, M_MSTATUS is the MRET restore.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MTVAL   = 3'd3,
    W_MSTATUS = 3'd4,
    M_MSTATUS = 3'd5,
    REDIRECT  = 3'd6
  } trapState_;

  // CSR write destination; CSR_NONE is the idle/reset encoding.
  typedef enum logic [2:0] {
    CSR_NONE    = 3'd0,
    CSR_MEPC    = 3'd1,
    CSR_MCAUSE  = 3'd2,
    CSR_MTVAL   = 3'd3,
    CSR_MSTATUS = 3'd4
  } destinationCSR_;

  // mcause reported for the external interrupt (interrupt bit set, code 11).
  localparam logic [31:0] INTERRUPT_CAUSE = 32'h8000_000B;

  // mstatus field positions.
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  // mtvec MODE value that selects vectored dispatch for interrupts.
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Everything captured at accept time so the sequence is immune to input changes.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] value;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        isMret;
  } trapHold_;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M as previous mode.
  function automatic logic [31:0] mstatusOnTrap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // MRET: restore MIE from MPIE, set MPIE, previous mode drops to U.
  function automatic logic [31:0] mstatusOnMret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - sequences trap/interrupt/MRET CSR updates and the PC redirect
module trap_controller
  import StaticPack::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           trapValid,
  input  logic [31:0]    trapCause,
  input  logic [31:0]    trapPC,
  input  logic [31:0]    trapValue,
  input  logic           mretValid,
  input  logic           interrupt,
  input  logic [31:0]    interruptPC,
  input  logic [31:0]    mstatusIn,
  input  logic [31:0]    mtvecIn,
  input  logic [31:0]    mepcIn,
  output logic           csrWriteEnable,
  output destinationCSR_ csrWriteAddress,
  output logic [31:0]    csrWriteData,
  output logic           flush,
  output logic           redirectValid,
  output logic           busy,
  output logic [31:0]    redirectPC
);

  trapState_   state;
  trapState_   nextState;
  trapHold_    hold;
  logic        acceptTrap;
  logic        acceptMret;
  logic        acceptIrq;
  logic        acceptAny;
  logic [31:0] redirectTarget;

  // Requests are only looked at in IDLE; anything arriving while busy is dropped.
  always_comb begin
    acceptTrap = (state == IDLE) && trapValid;
    acceptMret = (state == IDLE) && !trapValid && mretValid;
    acceptIrq  = (state == IDLE) && !trapValid && !mretValid
                 && interrupt && mstatusIn[MSTATUS_MIE];
    acceptAny  = acceptTrap || acceptMret || acceptIrq;
  end

  // Next-state: fixed one-cycle-per-step walk through the trap or MRET path.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (acceptTrap || acceptIrq) nextState = W_MEPC;
        else if (acceptMret)         nextState = M_MSTATUS;
      end
      W_MEPC:    nextState = W_MCAUSE;
      W_MCAUSE:  nextState = W_MTVAL;
      W_MTVAL:   nextState = W_MSTATUS;
      W_MSTATUS: nextState = REDIRECT;
      M_MSTATUS: nextState = REDIRECT;
      REDIRECT:  nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Capture the request and CSR snapshot on accept; interrupts substitute their own PC/cause.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (acceptAny) begin
      hold.pc      <= acceptIrq ? interruptPC     : trapPC;
      hold.cause   <= acceptIrq ? INTERRUPT_CAUSE : trapCause;
      hold.value   <= acceptIrq ? 32'd0           : trapValue;
      hold.mstatus <= mstatusIn;
      hold.mtvec   <= mtvecIn;
      hold.mepc    <= mepcIn;
      hold.isMret  <= acceptMret;
    end
  end

  // Redirect target: mepc for MRET, else mtvec base with vectored offset for interrupts.
  always_comb begin
    redirectTarget = {hold.mtvec[31:2], 2'b00};
    if (hold.isMret) begin
      redirectTarget = hold.mepc;
    end else if (hold.mtvec[1:0] == MTVEC_VECTORED && hold.cause[31]) begin
      redirectTarget = redirectTarget + {hold.cause[29:0], 2'b00};
    end
  end

  // Outputs decode purely from state so reset clears them without waiting for a clock.
  always_comb begin
    csrWriteEnable  = 1'b0;
    csrWriteAddress = CSR_NONE;
    csrWriteData    = 32'd0;
    redirectValid   = 1'b0;
    redirectPC      = 32'd0;
    busy            = (state != IDLE);
    flush           = (state != IDLE);
    case (state)
      W_MEPC: begin
        csrWriteEnable  = 1'b1;
        csrWriteAddress = CSR_MEPC;
        csrWriteData    = hold.pc;
      end
      W_MCAUSE: begin
        csrWriteEnable  = 1'b1;
        csrWriteAddress = CSR_MCAUSE;
        csrWriteData    = hold.cause;
      end
      W_MTVAL: begin
        csrWriteEnable  = 1'b1;
        csrWriteAddress = CSR_MTVAL;
        csrWriteData    = hold.value;
      end
      W_MSTATUS: begin
        csrWriteEnable  = 1'b1;
        csrWriteAddress = CSR_MSTATUS;
        csrWriteData    = mstatusOnTrap(hold.mstatus);
      end
      M_MSTATUS: begin
        csrWriteEnable  = 1'b1;
        csrWriteAddress = CSR_MSTATUS;
        csrWriteData    = mstatusOnMret(hold.mstatus);
      end
      REDIRECT: begin
        redirectValid = 1'b1;
        redirectPC    = redirectTarget;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - self-checking bench for trap_controller
module tb_trap_controller;
  import StaticPack::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           trapValid, mretValid, interrupt;
  logic [31:0]    trapCause, trapPC, trapValue, interruptPC;
  logic [31:0]    mstatusIn, mtvecIn, mepcIn;
  logic           csrWriteEnable, flush, redirectValid, busy;
  destinationCSR_ csrWriteAddress;
  logic [31:0]    csrWriteData, redirectPC;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic           we;
    destinationCSR_ addr;
    logic [31:0]    data;
    logic           rv;
    logic [31:0]    rpc;
  } obs_t;
  obs_t expQ[$];

  always #5 clock = ~clock;

  trap_controller dut (
    .clock(clock), .reset(reset),
    .trapValid(trapValid), .trapCause(trapCause), .trapPC(trapPC), .trapValue(trapValue),
    .mretValid(mretValid), .interrupt(interrupt), .interruptPC(interruptPC),
    .mstatusIn(mstatusIn), .mtvecIn(mtvecIn), .mepcIn(mepcIn),
    .csrWriteEnable(csrWriteEnable), .csrWriteAddress(csrWriteAddress), .csrWriteData(csrWriteData),
    .flush(flush), .redirectValid(redirectValid), .busy(busy), .redirectPC(redirectPC)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs;
    trapValid = 0; mretValid = 0; interrupt = 0;
    trapCause = 0; trapPC = 0; trapValue = 0; interruptPC = 0;
    mstatusIn = 0; mtvecIn = 0; mepcIn = 0;
  endtask

  // Reference model: architectural effect of trap entry / MRET on mstatus and target PC.
  function automatic logic [31:0] refTrapStatus(input logic [31:0] s);
    logic [31:0] r;
    r = (s & ~32'h0000_1888) | 32'h0000_1800;
    if ((s & 32'h8) != 0) r = r | 32'h80;
    return r;
  endfunction

  function automatic logic [31:0] refMretStatus(input logic [31:0] s);
    logic [31:0] r;
    r = (s & ~32'h0000_1888) | 32'h80;
    if ((s & 32'h80) != 0) r = r | 32'h8;
    return r;
  endfunction

  function automatic logic [31:0] refTarget(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec - (tvec % 4);
    if ((tvec % 4) == 1 && cause >= 32'h8000_0000) base = base + (cause - 32'h8000_0000) * 4;
    return base;
  endfunction

  task automatic modelTrap(input logic [31:0] pc, cause, value, ms, tvec);
    expQ.push_back('{1'b1, CSR_MEPC,    pc,                1'b0, 32'd0});
    expQ.push_back('{1'b1, CSR_MCAUSE,  cause,             1'b0, 32'd0});
    expQ.push_back('{1'b1, CSR_MTVAL,   value,             1'b0, 32'd0});
    expQ.push_back('{1'b1, CSR_MSTATUS, refTrapStatus(ms), 1'b0, 32'd0});
    expQ.push_back('{1'b0, CSR_NONE,    32'd0,             1'b1, refTarget(tvec, cause)});
  endtask

  task automatic modelMret(input logic [31:0] ms, epc);
    expQ.push_back('{1'b1, CSR_MSTATUS, refMretStatus(ms), 1'b0, 32'd0});
    expQ.push_back('{1'b0, CSR_NONE,    32'd0,             1'b1, epc});
  endtask

  task automatic test_reset;
    clearInputs();
    reset = 0;
    step(); step();
    checks++;
    if ({csrWriteEnable, csrWriteAddress, csrWriteData, flush, redirectValid, busy, redirectPC} !== 71'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h flush=%b rv=%b busy=%b rpc=%h expected all 0",
               csrWriteEnable, csrWriteAddress, csrWriteData, flush, redirectValid, busy, redirectPC);
    end
    reset = 1;
    step();
    checks++;
    if ({csrWriteEnable, csrWriteAddress, flush, redirectValid, busy} !== 7'd0) begin
      failures++;
      $display("FAIL post_reset_idle: got we=%b addr=%0d flush=%b rv=%b busy=%b expected 0",
               csrWriteEnable, csrWriteAddress, flush, redirectValid, busy);
    end
  endtask

  task automatic test_trap_directed;
    destinationCSR_ ea[4];
    logic [31:0]    ed[4];
    ea = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    ed = '{32'h100, 32'h2, 32'hDEAD, 32'h1880};
    trapValid = 1; trapCause = 2; trapPC = 32'h100; trapValue = 32'hDEAD;
    mtvecIn = 32'h200; mstatusIn = 32'h8;
    step();
    clearInputs();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({csrWriteEnable, csrWriteAddress, csrWriteData, redirectValid, busy, flush} !== {1'b1, ea[k], ed[k], 1'b0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL trap_write_%0d: got we=%b addr=%0d data=%h rv=%b busy=%b flush=%b expected addr=%0d data=%h",
                 k, csrWriteEnable, csrWriteAddress, csrWriteData, redirectValid, busy, flush, ea[k], ed[k]);
      end
      step();
    end
    checks++;
    if ({redirectValid, redirectPC, csrWriteEnable, busy} !== {1'b1, 32'h200, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL trap_redirect: got rv=%b rpc=%h we=%b busy=%b expected rv=1 rpc=00000200",
               redirectValid, redirectPC, csrWriteEnable, busy);
    end
    step();
    checks++;
    if ({busy, flush, redirectValid} !== 3'b000) begin
      failures++;
      $display("FAIL trap_back_idle: got busy=%b flush=%b rv=%b expected 0", busy, flush, redirectValid);
    end
  endtask

  task automatic test_interrupt_vectored;
    destinationCSR_ ea[4];
    logic [31:0]    ed[4];
    ea = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    ed = '{32'h40, 32'h8000_000B, 32'h0, 32'h1880};
    interrupt = 1; mstatusIn = 32'h8; mtvecIn = 32'h201; interruptPC = 32'h40;
    trapPC = 32'h777; trapCause = 32'h5; trapValue = 32'h99;
    step();
    clearInputs();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({csrWriteEnable, csrWriteAddress, csrWriteData} !== {1'b1, ea[k], ed[k]}) begin
        failures++;
        $display("FAIL irq_write_%0d: got we=%b addr=%0d data=%h expected addr=%0d data=%h",
                 k, csrWriteEnable, csrWriteAddress, csrWriteData, ea[k], ed[k]);
      end
      step();
    end
    checks++;
    if ({redirectValid, redirectPC} !== {1'b1, 32'h22C}) begin
      failures++;
      $display("FAIL irq_redirect: got rv=%b rpc=%h expected rv=1 rpc=0000022c", redirectValid, redirectPC);
    end
    step();
  endtask

  task automatic test_interrupt_masked;
    interrupt = 1; mstatusIn = 32'h0; interruptPC = 32'h80;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({busy, csrWriteEnable} !== 2'b00) begin
        failures++;
        $display("FAIL irq_masked_%0d: got busy=%b we=%b expected 0", k, busy, csrWriteEnable);
      end
    end
    trapValid = 1; trapCause = 32'h5; trapPC = 32'h500; trapValue = 32'h1; mstatusIn = 32'h8;
    step();
    clearInputs();
    checks++;
    if ({csrWriteAddress, csrWriteData} !== {CSR_MEPC, 32'h500}) begin
      failures++;
      $display("FAIL trap_over_irq_pc: got addr=%0d data=%h expected addr=1 data=00000500", csrWriteAddress, csrWriteData);
    end
    step();
    checks++;
    if ({csrWriteAddress, csrWriteData} !== {CSR_MCAUSE, 32'h5}) begin
      failures++;
      $display("FAIL trap_over_irq_cause: got addr=%0d data=%h expected addr=2 data=00000005", csrWriteAddress, csrWriteData);
    end
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_mret;
    mretValid = 1; mstatusIn = 32'h1880; mepcIn = 32'h104;
    step();
    clearInputs();
    checks++;
    if ({csrWriteEnable, csrWriteAddress, csrWriteData, redirectValid} !== {1'b1, CSR_MSTATUS, 32'h88, 1'b0}) begin
      failures++;
      $display("FAIL mret_status: got we=%b addr=%0d data=%h rv=%b expected we=1 addr=4 data=00000088 rv=0",
               csrWriteEnable, csrWriteAddress, csrWriteData, redirectValid);
    end
    step();
    checks++;
    if ({redirectValid, redirectPC, csrWriteEnable} !== {1'b1, 32'h104, 1'b0}) begin
      failures++;
      $display("FAIL mret_redirect: got rv=%b rpc=%h we=%b expected rv=1 rpc=00000104 we=0",
               redirectValid, redirectPC, csrWriteEnable);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mret_back_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_busy_and_midreset;
    trapValid = 1; trapCause = 32'h3; trapPC = 32'h300; trapValue = 32'h44; mstatusIn = 32'h8; mtvecIn = 32'h400;
    step();
    clearInputs();
    step();
    trapValid = 1; trapCause = 32'h7; trapPC = 32'h999; trapValue = 32'h55;
    checks++;
    if ({csrWriteAddress, csrWriteData} !== {CSR_MCAUSE, 32'h3}) begin
      failures++;
      $display("FAIL busy_cause: got addr=%0d data=%h expected addr=2 data=00000003", csrWriteAddress, csrWriteData);
    end
    step();
    clearInputs();
    checks++;
    if ({csrWriteAddress, csrWriteData} !== {CSR_MTVAL, 32'h44}) begin
      failures++;
      $display("FAIL busy_ignored: got addr=%0d data=%h expected addr=3 data=00000044", csrWriteAddress, csrWriteData);
    end
    reset = 0;
    #1;
    checks++;
    if ({csrWriteEnable, csrWriteAddress, csrWriteData, flush, redirectValid, busy, redirectPC} !== 71'd0) begin
      failures++;
      $display("FAIL midreset_async: got we=%b addr=%0d busy=%b expected all 0", csrWriteEnable, csrWriteAddress, busy);
    end
    step();
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({csrWriteEnable, csrWriteAddress, csrWriteData, flush, redirectValid, busy, redirectPC} !== 71'd0) begin
        failures++;
        $display("FAIL midreset_quiet_%0d: got we=%b addr=%0d data=%h rv=%b busy=%b expected all 0",
                 k, csrWriteEnable, csrWriteAddress, csrWriteData, redirectValid, busy);
      end
      step();
    end
  endtask

  task automatic test_random(input int n);
    for (int it = 0; it < n; it++) begin
      logic [31:0] ms, tv;
      clearInputs();
      trapValid = ($urandom_range(0, 3) == 0);
      mretValid = ($urandom_range(0, 2) == 0);
      interrupt = ($urandom_range(0, 1) == 0);
      trapCause = $urandom; trapPC = $urandom; trapValue = $urandom; interruptPC = $urandom;
      ms = $urandom; tv = $urandom; mepcIn = $urandom;
      if ($urandom_range(0, 1) == 1) tv[1:0] = 2'b01;
      mstatusIn = ms; mtvecIn = tv;
      expQ.delete();
      if (trapValid) modelTrap(trapPC, trapCause, trapValue, ms, tv);
      else if (mretValid) modelMret(ms, mepcIn);
      else if (interrupt && ms[3]) modelTrap(interruptPC, 32'h8000_000B, 32'd0, ms, tv);
      step();
      while (expQ.size() > 0) begin
        obs_t e;
        e = expQ.pop_front();
        checks++;
        if ({busy, flush, csrWriteEnable, csrWriteAddress, redirectValid} !== {2'b11, e.we, e.addr, e.rv}
            || (e.we && csrWriteData !== e.data) || (e.rv && redirectPC !== e.rpc)) begin
          failures++;
          $display("FAIL random_%0d: got busy=%b we=%b addr=%0d data=%h rv=%b rpc=%h expected we=%b addr=%0d data=%h rv=%b rpc=%h",
                   it, busy, csrWriteEnable, csrWriteAddress, csrWriteData, redirectValid, redirectPC,
                   e.we, e.addr, e.data, e.rv, e.rpc);
        end
        trapValid = $urandom_range(0, 1); mretValid = $urandom_range(0, 1); interrupt = $urandom_range(0, 1);
        trapCause = $urandom; trapPC = $urandom; trapValue = $urandom; interruptPC = $urandom;
        mstatusIn = $urandom | 32'h8; mtvecIn = $urandom; mepcIn = $urandom;
        step();
      end
      checks++;
      if ({busy, flush, csrWriteEnable, redirectValid} !== 4'b0000) begin
        failures++;
        $display("FAIL random_idle_%0d: got busy=%b flush=%b we=%b rv=%b expected 0",
                 it, busy, flush, csrWriteEnable, redirectValid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trap_directed();
    test_interrupt_vectored();
    test_interrupt_masked();
    test_mret();
    test_busy_and_midreset();
    test_random(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
